// File: rtl/multi_barrel_game_tracker.sv
// multi_barrel_game_tracker
// Score, lives and game-state tracker for one player against NUM_BARRELS
// independent hazards. Collision detection is combinational; the game FSM,
// score, lives and last-hit index are registered and drive Moore outputs.
module multi_barrel_game_tracker #(
    parameter int NUM_BARRELS     = 4,
    parameter int X_W             = 8,
    parameter int Y_W             = 7,
    parameter int HIT_W           = 9,
    parameter int HIT_H           = 4,
    parameter int MAX_LIVES       = 3,
    parameter int SCORE_W         = 9,
    parameter int TICK_DIV        = 25_000_000,
    parameter int GRACE_TICKS     = 2,
    parameter int POINTS_PER_TICK = 1,
    localparam int LIVES_W        = $clog2(MAX_LIVES + 1),
    localparam int IDX_W          = (NUM_BARRELS > 1) ? $clog2(NUM_BARRELS) : 1
) (
    input  logic                       Clk,
    input  logic                       ResetN,
    input  logic                       start,
    input  logic [X_W-1:0]             playerX,
    input  logic [Y_W-1:0]             playerY,
    input  logic [NUM_BARRELS*X_W-1:0] barrelX,
    input  logic [NUM_BARRELS*Y_W-1:0] barrelY,
    input  logic [NUM_BARRELS-1:0]     barrel_valid,
    output logic [SCORE_W-1:0]         score,
    output logic [LIVES_W-1:0]         lives,
    output logic [MAX_LIVES-1:0]       lives_mask,
    output logic                       hit_pulse,
    output logic [IDX_W-1:0]           hit_index,
    output logic                       invuln,
    output logic                       playing,
    output logic                       game_over
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GRACE_W = (GRACE_TICKS > 1) ? $clog2(GRACE_TICKS) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [GRACE_W-1:0] GRACE_LAST = GRACE_W'(GRACE_TICKS - 1);
    localparam logic [SCORE_W:0]   SCORE_MAX  = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_HIT   = 3'd2,
        S_GRACE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic                 tick;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   score_inc;
    logic [SCORE_W:0]     score_sum;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [IDX_W-1:0]     hit_index_q, hit_index_d;
    logic [GRACE_W-1:0]   grace_q, grace_d;
    logic [NUM_BARRELS-1:0] hit_vec;
    logic                 any_hit;
    logic [IDX_W-1:0]     hit_sel;

    // Free-running game tick divider; tick is high for the last count only.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            tick_cnt_q <= '0;
        end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt_q == TICK_LAST);

    // Per-barrel overlap test; one extra bit keeps px+HIT_W / py+HIT_H from wrapping.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BARRELS; gi++) begin : g_hit
            logic [X_W:0] bx_ext;
            logic [X_W:0] px_ext;
            logic [Y_W:0] by_ext;
            logic [Y_W:0] py_ext;
            logic         x_in;
            logic         y_in;

            assign bx_ext = {1'b0, barrelX[gi*X_W +: X_W]};
            assign px_ext = {1'b0, playerX};
            assign by_ext = {1'b0, barrelY[gi*Y_W +: Y_W]};
            assign py_ext = {1'b0, playerY};

            assign x_in = (bx_ext >= px_ext) && (bx_ext <= px_ext + (X_W+1)'(HIT_W));
            assign y_in = (by_ext >= py_ext) && (by_ext <= py_ext + (Y_W+1)'(HIT_H));

            assign hit_vec[gi] = barrel_valid[gi] && x_in && y_in;
        end
    endgenerate

    // Lowest-index colliding barrel wins when several overlap in the same cycle.
    always_comb begin
        hit_sel = '0;
        for (int i = NUM_BARRELS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_sel = IDX_W'(i);
            end
        end
    end

    assign any_hit = |hit_vec;

    // Saturating score increment.
    always_comb begin
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS_PER_TICK);
        if (score_sum > SCORE_MAX) begin
            score_inc = SCORE_MAX[SCORE_W-1:0];
        end else begin
            score_inc = score_sum[SCORE_W-1:0];
        end
    end

    // Game state and datapath registers.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q     <= S_IDLE;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            hit_index_q <= '0;
            grace_q     <= '0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            hit_index_q <= hit_index_d;
            grace_q     <= grace_d;
        end
    end

    // Next-state, score, lives and grace-counter logic.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        lives_d     = lives_q;
        hit_index_d = hit_index_q;
        grace_d     = grace_q;

        // Score keeps running through a hit and the grace window, not in IDLE/OVER.
        if (tick && (state_q == S_PLAY || state_q == S_HIT || state_q == S_GRACE)) begin
            score_d = score_inc;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            S_PLAY: begin
                if (any_hit) begin
                    state_d     = S_HIT;
                    hit_index_d = hit_sel;
                end
            end
            S_HIT: begin
                // Life is taken on the way out of HIT; the last life ends the game.
                lives_d = (lives_q != '0) ? (lives_q - LIVES_ONE) : '0;
                grace_d = '0;
                state_d = (lives_q <= LIVES_ONE) ? S_OVER : S_GRACE;
            end
            S_GRACE: begin
                if (tick) begin
                    if (grace_q == GRACE_LAST) begin
                        state_d = S_PLAY;
                    end else begin
                        grace_d = grace_q + GRACE_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore status outputs decoded from the registered state.
    always_comb begin
        hit_pulse = 1'b0;
        invuln    = 1'b0;
        playing   = 1'b0;
        game_over = 1'b0;
        case (state_q)
            S_PLAY:  playing = 1'b1;
            S_HIT:   begin playing = 1'b1; hit_pulse = 1'b1; end
            S_GRACE: begin playing = 1'b1; invuln = 1'b1; end
            S_OVER:  game_over = 1'b1;
            default: ;
        endcase
    end

    // Thermometer LED view of the remaining lives.
    generate
        for (gi = 0; gi < MAX_LIVES; gi++) begin : g_mask
            assign lives_mask[gi] = (lives_q > LIVES_W'(gi));
        end
    endgenerate

    assign score     = score_q;
    assign lives     = lives_q;
    assign hit_index = hit_index_q;

endmodule

// File: tb/tb_multi_barrel_game_tracker.sv
// Testbench for multi_barrel_game_tracker: scenario tasks plus a hit-event
// scoreboard (expected hits pushed when a collision is driven, popped on hit_pulse).
module tb_multi_barrel_game_tracker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  px;
    logic [6:0]  py;
    logic [31:0] bx;
    logic [27:0] by;
    logic [3:0]  bv;

    logic [8:0]  score;
    logic [1:0]  lives;
    logic [2:0]  lives_mask;
    logic        hit_pulse;
    logic [1:0]  hit_index;
    logic        invuln;
    logic        playing;
    logic        game_over;

    // second instance: narrow score for saturation
    logic        rst2_n;
    logic        start2;
    logic [3:0]  bv2;
    logic [2:0]  score2;
    logic [1:0]  lives2;
    logic [2:0]  lives_mask2;
    logic        hit_pulse2;
    logic [1:0]  hit_index2;
    logic        invuln2;
    logic        playing2;
    logic        game_over2;

    typedef struct {
        int idx;
        int lives_before;
    } hit_exp_t;

    hit_exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    logic prev_hit = 1'b0;

    multi_barrel_game_tracker #(
        .NUM_BARRELS(4), .TICK_DIV(4), .GRACE_TICKS(2), .MAX_LIVES(3), .SCORE_W(9)
    ) dut (
        .Clk(clk), .ResetN(rst_n), .start(start),
        .playerX(px), .playerY(py), .barrelX(bx), .barrelY(by), .barrel_valid(bv),
        .score(score), .lives(lives), .lives_mask(lives_mask), .hit_pulse(hit_pulse),
        .hit_index(hit_index), .invuln(invuln), .playing(playing), .game_over(game_over)
    );

    multi_barrel_game_tracker #(
        .NUM_BARRELS(4), .TICK_DIV(4), .GRACE_TICKS(2), .MAX_LIVES(3), .SCORE_W(3)
    ) dut_sat (
        .Clk(clk), .ResetN(rst2_n), .start(start2),
        .playerX(px), .playerY(py), .barrelX(bx), .barrelY(by), .barrel_valid(bv2),
        .score(score2), .lives(lives2), .lives_mask(lives_mask2), .hit_pulse(hit_pulse2),
        .hit_index(hit_index2), .invuln(invuln2), .playing(playing2), .game_over(game_over2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every hit_pulse must match the oldest expected hit.
    always @(negedge clk) begin
        hit_exp_t e;
        if (hit_pulse) begin
            checks++;
            if (prev_hit) begin
                errors++;
                $display("FAIL hit_pulse_width: hit_pulse high on consecutive cycles, required 1-cycle pulse");
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_hit: hit_pulse=1 hit_index=%0d, required no hit", hit_index);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (hit_index !== 2'(e.idx)) begin
                    errors++;
                    $display("FAIL hit_index: got %0d required %0d", hit_index, e.idx);
                end
                checks++;
                if (lives !== 2'(e.lives_before)) begin
                    errors++;
                    $display("FAIL hit_lives_before: got %0d required %0d", lives, e.lives_before);
                end
                $display("hit: index=%0d lives_before=%0d score=%0d", hit_index, lives, score);
            end
        end
        prev_hit <= hit_pulse;
    end

    task automatic clear_barrels();
        bx = {8'd200, 8'd200, 8'd200, 8'd200};
        by = {7'd100, 7'd100, 7'd100, 7'd100};
        bv = 4'b0000;
    endtask

    task automatic set_barrel(input int i, input int x, input int y);
        bx[i*8 +: 8] = 8'(x);
        by[i*7 +: 7] = 7'(y);
        bv[i] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0; bv2 = 4'b0000;
        px = 8'd10; py = 7'd10;
        clear_barrels();
        repeat (2) @(negedge clk);
        checks++;
        if (score !== 9'd0 || lives !== 2'd3 || hit_index !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: score=%0d lives=%0d hit_index=%0d, required 0/3/0", score, lives, hit_index);
        end
        checks++;
        if ({hit_pulse, invuln, playing, game_over} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {hit_pulse, invuln, playing, game_over});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (score !== 9'd0 || lives !== 2'd3 || lives_mask !== 3'b111 || playing !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: score=%0d lives=%0d mask=%b playing=%b, required 0/3/111/0",
                     score, lives, lives_mask, playing);
        end
        $display("test_reset: score=%0d lives=%0d mask=%b", score, lives, lives_mask);
    endtask

    task automatic test_score_accum();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (playing !== 1'b1 || score !== 9'd0) begin
            errors++;
            $display("FAIL start_play: playing=%b score=%0d, required 1/0", playing, score);
        end
        repeat (16) @(negedge clk);
        checks++;
        if (score !== 9'd4 || lives !== 2'd3) begin
            errors++;
            $display("FAIL score_16cyc: score=%0d lives=%0d, required 4/3", score, lives);
        end
        // start while playing must not restart the score
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (score < 9'd4 || playing !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: score=%0d playing=%b, required >=4/1", score, playing);
        end
        $display("test_score_accum: score=%0d lives=%0d", score, lives);
    endtask

    task automatic test_multi_hit_grace();
        int gcnt;
        set_barrel(1, 15, 12);
        set_barrel(3, 15, 12);
        exp_q.push_back('{idx: 1, lives_before: 3});
        @(negedge clk);
        checks++;
        if (hit_pulse !== 1'b1) begin
            errors++;
            $display("FAIL hit_latency: hit_pulse=%b one cycle after collision, required 1", hit_pulse);
        end
        @(negedge clk);
        checks++;
        if (lives !== 2'd2 || lives_mask !== 3'b011 || invuln !== 1'b1) begin
            errors++;
            $display("FAIL after_hit: lives=%0d mask=%b invuln=%b, required 2/011/1", lives, lives_mask, invuln);
        end
        gcnt = 0;
        for (int i = 0; i < 20 && invuln; i++) begin
            gcnt++;
            @(negedge clk);
        end
        clear_barrels();
        checks++;
        if (invuln !== 1'b0 || gcnt < 5 || gcnt > 8 || playing !== 1'b1) begin
            errors++;
            $display("FAIL grace_len: grace cycles=%0d invuln=%b playing=%b, required 5..8/0/1", gcnt, invuln, playing);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (lives !== 2'd2) begin
            errors++;
            $display("FAIL no_second_hit: lives=%0d required 2", lives);
        end
        $display("test_multi_hit_grace: grace_cycles=%0d lives=%0d", gcnt, lives);
    endtask

    task automatic test_boundary();
        // x just past the hitbox, x just before player, y just past the hitbox, invalid overlap
        set_barrel(0, 20, 10);
        repeat (4) @(negedge clk);
        clear_barrels();
        set_barrel(0, 9, 12);
        repeat (4) @(negedge clk);
        clear_barrels();
        set_barrel(0, 15, 15);
        repeat (4) @(negedge clk);
        clear_barrels();
        bx[7:0] = 8'd12; by[6:0] = 7'd12; bv = 4'b0000;
        repeat (4) @(negedge clk);
        checks++;
        if (lives !== 2'd2 || playing !== 1'b1 || invuln !== 1'b0) begin
            errors++;
            $display("FAIL boundary_no_hit: lives=%0d playing=%b invuln=%b, required 2/1/0", lives, playing, invuln);
        end
        // far corner of the hitbox is inclusive
        clear_barrels();
        set_barrel(0, 19, 14);
        exp_q.push_back('{idx: 0, lives_before: 2});
        @(negedge clk);
        checks++;
        if (hit_pulse !== 1'b1) begin
            errors++;
            $display("FAIL boundary_hit: hit_pulse=%b required 1", hit_pulse);
        end
        clear_barrels();
        for (int i = 0; i < 20 && (hit_pulse || invuln); i++) @(negedge clk);
        checks++;
        if (lives !== 2'd1 || lives_mask !== 3'b001 || playing !== 1'b1) begin
            errors++;
            $display("FAIL boundary_after: lives=%0d mask=%b playing=%b, required 1/001/1", lives, lives_mask, playing);
        end
        $display("test_boundary: lives=%0d", lives);
    endtask

    task automatic test_game_over();
        logic [8:0] frozen;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int h = 0; h < 3; h++) begin
            repeat (3) @(negedge clk);
            set_barrel(h, 10 + h, 10 + h);
            exp_q.push_back('{idx: h, lives_before: 3 - h});
            for (int i = 0; i < 4 && !hit_pulse; i++) @(negedge clk);
            checks++;
            if (hit_pulse !== 1'b1) begin
                errors++;
                $display("FAIL go_hit%0d: hit_pulse=%b required 1", h, hit_pulse);
            end
            clear_barrels();
            for (int i = 0; i < 20 && (hit_pulse || invuln); i++) @(negedge clk);
            checks++;
            if (lives !== 2'(2 - h)) begin
                errors++;
                $display("FAIL go_lives%0d: lives=%0d required %0d", h, lives, 2 - h);
            end
        end
        checks++;
        if (game_over !== 1'b1 || playing !== 1'b0 || lives_mask !== 3'b000) begin
            errors++;
            $display("FAIL over_state: game_over=%b playing=%b mask=%b, required 1/0/000", game_over, playing, lives_mask);
        end
        frozen = score;
        set_barrel(2, 12, 12);
        repeat (30) @(negedge clk);
        clear_barrels();
        checks++;
        if (score !== frozen || lives !== 2'd0 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL over_frozen: score=%0d lives=%0d game_over=%b, required %0d/0/1", score, lives, game_over, frozen);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (score !== 9'd0 || lives !== 2'd3 || lives_mask !== 3'b111 || playing !== 1'b1 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart: score=%0d lives=%0d mask=%b playing=%b game_over=%b, required 0/3/111/1/0",
                     score, lives, lives_mask, playing, game_over);
        end
        $display("test_game_over: frozen_score=%0d restart_lives=%0d", frozen, lives);
    endtask

    task automatic test_saturation_and_reset();
        logic wrapped;
        logic [2:0] prev;
        rst2_n = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wrapped = 1'b0;
        prev = score2;
        repeat (40) begin
            @(negedge clk);
            if (score2 < prev) wrapped = 1'b1;
            prev = score2;
        end
        checks++;
        if (score2 !== 3'd7 || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL saturate: score=%0d wrapped=%b, required 7/0", score2, wrapped);
        end
        // reset in the middle of the grace window
        set_barrel(2, 14, 11);
        exp_q.push_back('{idx: 2, lives_before: 3});
        for (int i = 0; i < 4 && !hit_pulse; i++) @(negedge clk);
        clear_barrels();
        @(negedge clk);
        checks++;
        if (invuln !== 1'b1 || hit_index !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_grace: invuln=%b hit_index=%0d, required 1/2", invuln, hit_index);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (score !== 9'd0 || lives !== 2'd3 || hit_index !== 2'd0 ||
            {hit_pulse, invuln, playing, game_over} !== 4'b0000) begin
            errors++;
            $display("FAIL grace_reset: score=%0d lives=%0d idx=%0d flags=%b, required 0/3/0/0000",
                     score, lives, hit_index, {hit_pulse, invuln, playing, game_over});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_saturation_and_reset: sat_score=%0d lives=%0d", score2, lives);
    endtask

    initial begin
        test_reset();
        test_score_accum();
        test_multi_hit_grace();
        test_boundary();
        test_game_over();
        test_saturation_and_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_hits: %0d expected hits never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
